// File: rtl/color_pkg.sv
// Shared types for the colour palette generator: RGB colour names, draw FSM
// states and the slot-index width helper.
package color_pkg;

    localparam int COLOR_W_DEF = 3;

    // RGB, one bit per channel, ordered {R,G,B}
    typedef enum logic [2:0] {
        BLACK   = 3'b000,
        BLUE    = 3'b001,
        GREEN   = 3'b010,
        CYAN    = 3'b011,
        RED     = 3'b100,
        MAGENTA = 3'b101,
        YELLOW  = 3'b110,
        WHITE   = 3'b111
    } color_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BALL = 2'd1,
        POS  = 2'd2,
        PLAT = 2'd3
    } state_t;

    // Width of a platform slot index; never narrower than one bit
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/galois_lfsr.sv
// Galois LFSR with synchronous load. A zero load value is replaced by SEED
// so the register can never lock up in the all-zero state.
module galois_lfsr #(
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS   = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED   = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              step,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    output logic [LFSR_W-1:0] state
);

    // Load has priority over stepping; shift right, fold taps in when LSB is set
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= SEED;
        else if (load)
            state <= (load_val == '0) ? SEED : load_val;
        else if (step)
            state <= state[0] ? ((state >> 1) ^ TAPS) : (state >> 1);
    end

endmodule

// File: rtl/color_palette_gen.sv
// Colour palette generator: per request draws one non-black ball colour and
// NUM_PLATS platform colours from an LFSR, with exactly one platform (at
// match_pos) carrying the ball colour.
// Optional build macro DISTINCT_PLATS_EN: all platform colours pairwise distinct.
//
// state | meaning
// IDLE  | waiting for req; LFSR free-runs only while enable=1
// BALL  | redraw until candidate colour is non-black, latch as ball
// POS   | redraw until index candidate is a valid slot, latch as match slot
// PLAT  | fill slots in order; match slot takes the ball, others redraw until legal
module color_palette_gen
    import color_pkg::*;
#(
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] TAPS      = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
    parameter int                NUM_PLATS = 4,
    parameter int                COLOR_W   = COLOR_W_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           seed_load,
    input  logic [LFSR_W-1:0]              seed,
    input  logic                           req,
    output logic                           busy,
    output logic                           valid,
    output logic [COLOR_W-1:0]             ball_color,
    output logic [NUM_PLATS*COLOR_W-1:0]   plat_colors,
    output logic [idx_w(NUM_PLATS)-1:0]    match_pos,
    output logic [LFSR_W-1:0]              lfsr_state
);

    localparam int                 IDX_W    = idx_w(NUM_PLATS);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_PLATS - 1);
    localparam logic [COLOR_W-1:0] NO_COLOR = COLOR_W'(BLACK);

`ifdef DISTINCT_PLATS_EN
    // Not enough non-black, non-ball colours to make every platform distinct
    if (NUM_PLATS - 1 > (1 << COLOR_W) - 2) begin : g_bad_cfg
        $error("color_palette_gen: NUM_PLATS too large for distinct colours");
    end
`endif

    state_t                   state;
    logic [COLOR_W-1:0]       work_ball;
    logic [IDX_W-1:0]         work_pos;
    logic [IDX_W-1:0]         idx;
    logic [COLOR_W-1:0]       work_plat [NUM_PLATS];

    logic [COLOR_W-1:0]       cand;
    logic [IDX_W-1:0]         pos_cand;
    logic                     is_match;
    logic                     cand_ok;
    logic                     slot_ok;
    logic [COLOR_W-1:0]       slot_val;
    logic [NUM_PLATS*COLOR_W-1:0] plat_next;

    galois_lfsr #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS),
        .SEED   (SEED)
    ) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .step     (enable || (state != IDLE)),
        .load     (seed_load),
        .load_val (seed),
        .state    (lfsr_state)
    );

    assign cand     = lfsr_state[COLOR_W-1:0];
    assign pos_cand = lfsr_state[IDX_W-1:0];
    assign is_match = (idx == work_pos);
    assign slot_val = is_match ? work_ball : cand;
    assign slot_ok  = is_match || cand_ok;

    // Legality of the current colour candidate for a non-match slot
    always_comb begin
        cand_ok = (cand != NO_COLOR) && (cand != work_ball);
`ifdef DISTINCT_PLATS_EN
        for (int j = 0; j < NUM_PLATS; j++) begin
            if ((IDX_W'(j) < idx) && (work_plat[j] == cand))
                cand_ok = 1'b0;
        end
`endif
    end

    // Work slots packed for output, with the slot being filled this cycle merged in
    always_comb begin
        plat_next = '0;
        for (int i = 0; i < NUM_PLATS; i++)
            plat_next[i*COLOR_W +: COLOR_W] = (IDX_W'(i) == idx) ? slot_val : work_plat[i];
    end

    // Draw sequencer; seed_load aborts silently, palette outputs only move on valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            valid       <= 1'b0;
            ball_color  <= '0;
            plat_colors <= '0;
            match_pos   <= '0;
            work_ball   <= '0;
            work_pos    <= '0;
            idx         <= '0;
            for (int i = 0; i < NUM_PLATS; i++)
                work_plat[i] <= '0;
        end else begin
            valid <= 1'b0;
            if (seed_load) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (req) begin
                            state <= BALL;
                            busy  <= 1'b1;
                        end
                    end
                    BALL: begin
                        if (cand != NO_COLOR) begin
                            work_ball <= cand;
                            state     <= POS;
                        end
                    end
                    POS: begin
                        if (32'(pos_cand) < 32'(NUM_PLATS)) begin
                            work_pos <= pos_cand;
                            idx      <= '0;
                            state    <= PLAT;
                        end
                    end
                    PLAT: begin
                        if (slot_ok) begin
                            work_plat[idx] <= slot_val;
                            if (idx == LAST_IDX) begin
                                ball_color  <= work_ball;
                                plat_colors <= plat_next;
                                match_pos   <= work_pos;
                                valid       <= 1'b1;
                                busy        <= 1'b0;
                                state       <= IDLE;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_color_palette_gen.sv
// Self-checking bench for color_palette_gen. The reference model treats a draw
// as consumption of a stream of LFSR values and predicts colours, slot,
// latency and final LFSR value for each request.
module tb_color_palette_gen;

    localparam int NP     = 4;
    localparam int CW     = 3;
    localparam int N_SOAK = 4000;

    logic          clk;
    logic          reset;
    logic          enable;
    logic          seed_load;
    logic [15:0]   seed;
    logic          req;
    logic          busy;
    logic          valid;
    logic [CW-1:0] ball_color;
    logic [NP*CW-1:0] plat_colors;
    logic [1:0]    match_pos;
    logic [15:0]   lfsr_state;

    int n_pass;
    int n_total;

    logic [CW-1:0]    saved_ball;
    logic [NP*CW-1:0] saved_plats;
    logic [1:0]       saved_pos;

    color_palette_gen dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .seed_load   (seed_load),
        .seed        (seed),
        .req         (req),
        .busy        (busy),
        .valid       (valid),
        .ball_color  (ball_color),
        .plat_colors (plat_colors),
        .match_pos   (match_pos),
        .lfsr_state  (lfsr_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // Walk the LFSR value stream the way the spec describes a draw
    function automatic void model_draw(input logic [15:0] start,
                                       output logic [2:0] ball,
                                       output logic [11:0] plats,
                                       output int pos,
                                       output int n,
                                       output logic [15:0] fin);
        logic [15:0] v;
        logic [2:0]  c;
        bit          ok;
        v = start; n = 0; plats = '0; ball = 3'd0; c = 3'd0;
        while (ball == 3'd0) begin
            ball = v[2:0]; v = step(v); n++;
        end
        pos = NP;
        while (pos >= NP) begin
            pos = int'(v[1:0]); v = step(v); n++;
        end
        for (int s = 0; s < NP; s++) begin
            if (s == pos) begin
                plats[s*3 +: 3] = ball; v = step(v); n++;
            end else begin
                ok = 1'b0;
                while (!ok) begin
                    c = v[2:0]; v = step(v); n++;
                    ok = (c != 3'd0) && (c != ball);
`ifdef DISTINCT_PLATS_EN
                    for (int k = 0; k < s; k++)
                        if (plats[k*3 +: 3] == c) ok = 1'b0;
`endif
                end
                plats[s*3 +: 3] = c;
            end
        end
        fin = v;
    endfunction

    function automatic bit invariants_ok(input logic [2:0] b, input logic [11:0] p, input logic [1:0] mp);
        bit ok;
        ok = (b != 3'd0) && (p[mp*3 +: 3] == b);
        for (int s = 0; s < NP; s++) begin
            if (s != int'(mp) && (p[s*3 +: 3] == 3'd0 || p[s*3 +: 3] == b)) ok = 1'b0;
`ifdef DISTINCT_PLATS_EN
            for (int k = 0; k < s; k++)
                if (p[k*3 +: 3] == p[s*3 +: 3]) ok = 1'b0;
`endif
        end
        return ok;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; seed_load = 1'b0; seed = '0; req = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        n_total++;
        if ({busy, valid, ball_color, plat_colors, match_pos} !== '0 || lfsr_state !== 16'hACE1)
            $display("FAIL reset_state: busy=%b valid=%b ball=%h plats=%h pos=%h lfsr=%h, required all 0 and lfsr=ace1",
                     busy, valid, ball_color, plat_colors, match_pos, lfsr_state);
        else n_pass++;
    endtask

    task automatic test_lfsr_step();
        seed_load = 1'b1; seed = 16'h0001; tick(); seed_load = 1'b0;
        n_total++;
        if (lfsr_state !== 16'h0001) $display("FAIL seed_load: lfsr=%h required 0001", lfsr_state);
        else n_pass++;
        enable = 1'b1; tick();
        n_total++;
        if (lfsr_state !== 16'hB400) $display("FAIL lfsr_step1: lfsr=%h required b400", lfsr_state);
        else n_pass++;
        tick(); enable = 1'b0;
        n_total++;
        if (lfsr_state !== 16'h5A00) $display("FAIL lfsr_step2: lfsr=%h required 5a00", lfsr_state);
        else n_pass++;
    endtask

    task automatic test_zero_seed();
        seed_load = 1'b1; seed = 16'h0000; tick(); seed_load = 1'b0;
        n_total++;
        if (lfsr_state !== 16'hACE1) $display("FAIL zero_seed: lfsr=%h required ace1", lfsr_state);
        else n_pass++;
    endtask

    task automatic test_draw();
        logic [2:0] e_ball; logic [11:0] e_plats; int e_pos; int e_n; logic [15:0] e_fin;
        int cnt;
        seed_load = 1'b1; seed = 16'hACE1; enable = 1'b0; tick(); seed_load = 1'b0;
        req = 1'b1; tick(); req = 1'b0;
        model_draw(16'hACE1, e_ball, e_plats, e_pos, e_n, e_fin);
        cnt = 0;
        while (cnt < 100 && !valid) begin tick(); cnt++; end
        n_total++;
        if (!valid || cnt != e_n || cnt < NP + 2)
            $display("FAIL draw_latency: valid=%b after %0d edges, required %0d", valid, cnt, e_n);
        else n_pass++;
        n_total++;
        if (ball_color !== e_ball || plat_colors !== e_plats || int'(match_pos) != e_pos)
            $display("FAIL draw_palette: ball=%h plats=%h pos=%0d, required ball=%h plats=%h pos=%0d",
                     ball_color, plat_colors, match_pos, e_ball, e_plats, e_pos);
        else n_pass++;
        n_total++;
        if (!invariants_ok(ball_color, plat_colors, match_pos))
            $display("FAIL draw_invariants: ball=%h plats=%h pos=%0d, required legal palette", ball_color, plat_colors, match_pos);
        else n_pass++;
        saved_ball = ball_color; saved_plats = plat_colors; saved_pos = match_pos;
        tick();
        n_total++;
        if (valid !== 1'b0 || busy !== 1'b0 || ball_color !== saved_ball || plat_colors !== saved_plats)
            $display("FAIL draw_pulse: valid=%b busy=%b after pulse, required 0 0 with outputs held", valid, busy);
        else n_pass++;
    endtask

    task automatic test_abort();
        bit seen_valid;
        seed_load = 1'b1; seed = 16'hACE1; tick(); seed_load = 1'b0;
        req = 1'b1; tick(); req = 1'b0;
        tick(); tick();
        seed_load = 1'b1; seed = 16'h1234; tick(); seed_load = 1'b0;
        n_total++;
        if (busy !== 1'b0 || valid !== 1'b0 || lfsr_state !== 16'h1234)
            $display("FAIL abort_state: busy=%b valid=%b lfsr=%h, required 0 0 1234", busy, valid, lfsr_state);
        else n_pass++;
        n_total++;
        if (ball_color !== saved_ball || plat_colors !== saved_plats || match_pos !== saved_pos)
            $display("FAIL abort_hold: ball=%h plats=%h pos=%h, required %h %h %h",
                     ball_color, plat_colors, match_pos, saved_ball, saved_plats, saved_pos);
        else n_pass++;
        seen_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin tick(); if (valid || busy) seen_valid = 1'b1; end
        n_total++;
        if (seen_valid) $display("FAIL abort_quiet: valid/busy seen=%b after abort, required 0", seen_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid_draw();
        seed_load = 1'b1; seed = 16'hACE1; tick(); seed_load = 1'b0;
        req = 1'b1; tick(); req = 1'b0;
        tick(); tick();
        #2 reset = 1'b1;
        #1;
        n_total++;
        if ({busy, valid, ball_color, plat_colors, match_pos} !== '0 || lfsr_state !== 16'hACE1)
            $display("FAIL reset_mid_draw: busy=%b valid=%b ball=%h plats=%h pos=%h lfsr=%h, required 0s and ace1",
                     busy, valid, ball_color, plat_colors, match_pos, lfsr_state);
        else n_pass++;
        tick(); reset = 1'b0; tick();
    endtask

    task automatic test_back_to_back();
        logic [2:0] e_ball; logic [11:0] e_plats; int e_pos; int e_n; logic [15:0] m;
        int cnt; int gap; bit busy_bad; bit timed_out;
        bit seen_pos [NP];
        bit seen_ball [8];
        bit all_pos; bit all_ball;
        for (int i = 0; i < NP; i++) seen_pos[i] = 1'b0;
        for (int i = 0; i < 8; i++) seen_ball[i] = 1'b0;
        m = lfsr_state;
        timed_out = 1'b0;
        for (int d = 0; d < N_SOAK && !timed_out; d++) begin
            if ($urandom_range(0, 3) == 0) begin
                gap = int'($urandom_range(1, 3));
                for (int g = 0; g < gap; g++) begin
                    req = 1'b0; enable = 1'($urandom_range(0, 1)); tick();
                    if (enable) m = step(m);
                end
            end
            req = 1'b1; enable = 1'($urandom_range(0, 1)); tick();
            if (enable) m = step(m);
            model_draw(m, e_ball, e_plats, e_pos, e_n, m);
            cnt = 0; busy_bad = 1'b0;
            while (cnt < 200) begin
                if (!busy) busy_bad = 1'b1;
                req = 1'($urandom_range(0, 1)); enable = 1'($urandom_range(0, 1));
                tick(); cnt++;
                if (valid) break;
            end
            n_total++;
            if (!valid || cnt != e_n) begin
                $display("FAIL soak_latency: draw %0d valid=%b after %0d edges, required %0d", d, valid, cnt, e_n);
                if (!valid) timed_out = 1'b1;
            end else n_pass++;
            n_total++;
            if (busy_bad || busy !== 1'b0)
                $display("FAIL soak_busy: draw %0d busy dropped early=%b busy at valid=%b, required 0 0", d, busy_bad, busy);
            else n_pass++;
            n_total++;
            if (ball_color !== e_ball || plat_colors !== e_plats || int'(match_pos) != e_pos)
                $display("FAIL soak_palette: draw %0d ball=%h plats=%h pos=%0d, required %h %h %0d",
                         d, ball_color, plat_colors, match_pos, e_ball, e_plats, e_pos);
            else n_pass++;
            n_total++;
            if (lfsr_state !== m)
                $display("FAIL soak_lfsr: draw %0d lfsr=%h required %h", d, lfsr_state, m);
            else n_pass++;
            n_total++;
            if (!invariants_ok(ball_color, plat_colors, match_pos))
                $display("FAIL soak_invariants: draw %0d ball=%h plats=%h pos=%0d", d, ball_color, plat_colors, match_pos);
            else n_pass++;
            seen_pos[match_pos] = 1'b1;
            seen_ball[ball_color] = 1'b1;
            m = lfsr_state;
        end
        req = 1'b0; enable = 1'b0;
        all_pos = 1'b1; all_ball = 1'b1;
        for (int i = 0; i < NP; i++) if (!seen_pos[i]) all_pos = 1'b0;
        for (int i = 1; i < 8; i++) if (!seen_ball[i]) all_ball = 1'b0;
        n_total++;
        if (!all_pos) $display("FAIL cover_match_pos: some slot never matched, required all 0..3");
        else n_pass++;
        n_total++;
        if (!all_ball) $display("FAIL cover_ball: some ball colour never drawn, required all 1..7");
        else n_pass++;
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        reset = 1'b1; enable = 1'b0; seed_load = 1'b0; seed = '0; req = 1'b0;
        saved_ball = '0; saved_plats = '0; saved_pos = '0;
        test_reset();
        test_lfsr_step();
        test_zero_seed();
        test_draw();
        test_abort();
        test_reset_mid_draw();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
